// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD conversion path.
// Holds the default widths and the converter state encoding.
package bcd_pkg;

    // Default binary width (matches the div_16 quotient) and BCD digit count
    localparam int BIN_W      = 16;
    localparam int BCD_DIGITS = 5;

    // Counter must be able to hold the full bit count BIN_W
    localparam int CNT_W      = $clog2(BIN_W + 1);

    // Converter control states
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } bcd_state_t;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Single-digit double-dabble correction.
// A digit of 5 or more gets +3 so that the following left shift carries
// correctly into the next decimal digit. The largest input seen in practice
// is 9, so the result never exceeds 12 and always fits in 4 bits.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Add-3 correction whenever the digit would overflow after doubling
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_16.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A start pulse in IDLE captures the binary value; WIDTH clocks later the
// packed BCD result is registered, done pulses for one cycle and busy drops.
// The start/done pair mirrors the div_16 handshake so they chain directly.
module bin2bcd_16
    import bcd_pkg::*;
#(
    parameter int WIDTH  = BIN_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    // Counter width derived from this instance's WIDTH so it can hold WIDTH
    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_t             r_state;
    logic [WIDTH-1:0]       r_shBin;
    logic [4*DIGITS-1:0]    r_shBcd;
    logic [CW-1:0]          r_cnt;
    logic [4*DIGITS-1:0]    r_bcd;
    logic                   r_busy;
    logic                   r_done;

    logic [4*DIGITS-1:0]    w_adjBcd;
    logic [4*DIGITS-1:0]    w_nextBcd;
    logic [WIDTH-1:0]       w_nextBin;

    // Per-digit add-3 correction; digits are independent of each other
    for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
        bcd_digit_adj u_adj (
            .i_digit (r_shBcd[4*g +: 4]),
            .o_digit (w_adjBcd[4*g +: 4])
        );
    end

    // Concatenated left shift: binary MSB enters bit 0 of the ones digit
    assign w_nextBcd = {w_adjBcd[4*DIGITS-2:0], r_shBin[WIDTH-1]};
    assign w_nextBin = {r_shBin[WIDTH-2:0], 1'b0};

    // Control FSM with counter, shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shBin <= '0;
            r_shBcd <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_shBin <= bin;
                        r_shBcd <= '0;
                        r_cnt   <= CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_shBcd <= w_nextBcd;
                    r_shBin <= w_nextBin;
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_bcd   <= w_nextBcd;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign busy = r_busy;
    assign done = r_done;

endmodule : bin2bcd_16

// File: tb/tb_bin2bcd_16.sv
// Self-checking bench for bin2bcd_16: directed corner cases plus random
// values, compared against a decimal-digit reference built with / and %.
module tb_bin2bcd_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [19:0] lastResult = '0;

    bin2bcd_16 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: split the integer into decimal digits, ones digit lowest
    function automatic logic [19:0] refBcd(input int value);
        logic [19:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One counted comparison
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a start request with the given value at the next negedge
    task automatic applyStimulus(input logic [15:0] value);
        @(negedge clk);
        start = 1'b1;
        bin   = value;
    endtask

    // Full single conversion with latency, hold, pulse-width and result checks
    task automatic convert(input logic [15:0] value, input string tag);
        logic [19:0] expBcd;
        int lat;
        expBcd = refBcd(int'(value));
        applyStimulus(value);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = 16'($urandom);
        checkOutput({tag, "_busy_on"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 8) begin
                checkOutput({tag, "_bcd_hold"}, 32'(bcd), 32'(lastResult));
                bin = 16'($urandom);
            end
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd16);
        checkOutput({tag, "_bcd"}, 32'(bcd), 32'(expBcd));
        checkOutput({tag, "_busy_off"}, 32'(busy), 32'd0);
        lastResult = expBcd;
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int doneCount;
        int firstDone;
        logic [15:0] vals [4];
        logic [15:0] rv;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        #12;
        checkOutput("reset_bcd",  32'(bcd),  32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] directed values");
        convert(16'd0,     "zero");
        convert(16'd65535, "max");
        convert(16'd1234,  "v1234");
        convert(16'd40960, "v40960");

        $display("[TB] start while busy is ignored");
        applyStimulus(16'd321);
        @(posedge clk); #1;
        start = 1'b0;
        doneCount = 0;
        firstDone = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                start = 1'b1;
                bin   = 16'd999;
            end else if (c == 6) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                doneCount++;
                if (firstDone == 0) begin
                    firstDone = c;
                    checkOutput("ignore_bcd", 32'(bcd), 32'(refBcd(321)));
                end
            end
        end
        checkOutput("ignore_latency", 32'(firstDone), 32'd16);
        checkOutput("ignore_done_count", 32'(doneCount), 32'd1);
        lastResult = refBcd(321);

        $display("[TB] back-to-back with start held high");
        vals[0] = 16'd9;
        vals[1] = 16'd10;
        vals[2] = 16'd99;
        vals[3] = 16'd100;
        applyStimulus(vals[0]);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!done && lat < 40);
            checkOutput($sformatf("b2b%0d_interval", i), 32'(lat), (i == 0) ? 32'd16 : 32'd17);
            checkOutput($sformatf("b2b%0d_bcd", i), 32'(bcd), 32'(refBcd(int'(vals[i]))));
            if (i < 3) bin = vals[i+1];
            else       start = 1'b0;
        end
        lastResult = refBcd(100);
        repeat (20) begin
            @(posedge clk); #1;
            if (done) checkOutput("b2b_extra_done", 32'(done), 32'd0);
        end

        $display("[TB] asynchronous reset mid-conversion");
        applyStimulus(16'd500);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_bcd",  32'(bcd),  32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        lastResult = '0;
        @(negedge clk);
        rst = 1'b0;
        doneCount = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) doneCount++;
        end
        checkOutput("midrst_no_done", 32'(doneCount), 32'd0);
        convert(16'd42, "after_rst");

        $display("[TB] quotient of 50000/7 from the divider path");
        convert(16'(50000 / 7), "div");
        checkOutput("div_digits", 32'(lastResult), 32'h07142);

        $display("[TB] random values");
        for (int n = 0; n < 20; n++) begin
            rv = 16'($urandom_range(0, 65535));
            convert(rv, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bin2bcd_16

// File: doc/bin2bcd_16.md
# bin2bcd_16

Sequential binary-to-BCD converter that consumes the 16-bit quotient produced by the `div_16` divider and emits five packed BCD digits for the score/status display path. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It runs under a simple start/done handshake that mirrors the divider's `init_in`/`done` pair, so the divider's `done` can drive `start` directly.

## Interface

Parameters:
- `WIDTH`, 16: binary input width.
- `DIGITS`, 5: BCD output digits. Must satisfy DIGITS ≥ ceil(WIDTH·log10 2).

Ports:
- `clk`, in, 1: single clock, rising-edge.
- `rst`, in, 1: asynchronous, active-high reset. One clock (`clk`); reset is asynchronous and active-high.
- `start`, in, 1: request conversion of `bin`. Sampled only in IDLE.
- `bin`, in, WIDTH: binary value. Captured on the accepting edge.
- `bcd`, out, 4·DIGITS: packed BCD result. Digit 0 (ones) is in [3:0]. Holds the last result.
- `busy`, out, 1: conversion in progress.
- `done`, out, 1: single-cycle pulse when `bcd` has been updated.

## Operation

- FSM states:
  - IDLE: `busy`=0. If `start`=1, load `sh_bin`←`bin`, clear `sh_bcd`, set `cnt`←WIDTH, go to CONV.
  - CONV: `busy`=1. Each cycle:
    - Every 4-bit digit of `sh_bcd` ≥5 gets +3.
    - Then `{sh_bcd, sh_bin}` shifts left by 1, MSB of `sh_bin` entering digit 0 bit 0.
    - `cnt` decrements.
    - On the cycle where `cnt`=1 (the last shift), register the adjusted-and-shifted value into `bcd`, set `done`=1, and go to IDLE.
- Digit adjust is purely per-digit. Digits are not compared against each other. The +3 never overflows a digit because an adjusted digit is ≤12.
- Maximum output for WIDTH=16 is 65535, giving `bcd`=0x65535. The top digit never exceeds 6.
- `start` while `busy`=1 is ignored. No queueing, no error flag.
- `bin` changes after the accept edge have no effect on the running conversion.
- `bcd` changes only on the completing edge, or on reset.
- Reset values (asynchronous on `rst`=1, any state):
  - state=IDLE
  - `bcd`=0
  - `busy`=0
  - `done`=0
  - `cnt`=0
  - shift registers=0
- Reset mid-conversion aborts it. No `done` is produced and `bcd` reads 0.

## Timing

- `start` is sampled at edge k. `busy`=1 from after edge k through edge k+WIDTH.
- At edge k+WIDTH, `bcd` is updated, `done` rises, and `busy` falls. `done` is high for exactly one cycle.
- Latency is WIDTH clocks from the accept edge to valid `bcd`/`done` (16 for the default).
- Back-to-back operation: `start` high during the `done` cycle is accepted at edge k+WIDTH+1. Sustained throughput is one conversion per WIDTH+1 clocks.
- `bcd` is registered. `busy` and `done` are registered FSM outputs with no combinational path from `start`.
- `rst` deassertion must be synchronous to `clk`. Reset-release synchronization is provided externally.

## Structure

- Shared package `bcd_pkg`:
  - constants `BIN_W`=16 and `BCD_DIGITS`=5
  - `CNT_W`=$clog2(BIN_W+1)
  - state enum {IDLE, CONV}
- Sub-module `bcd_digit_adj`: 4-bit in, 4-bit out, combinational. It adds 3 when the input is ≥5. Instantiate it DIGITS times in a generate loop.
- Top level holds the FSM, counter, shift registers, and output register.

## Test plan

- `bin`=0 and `start` pulse → after 16 clocks, `done`=1 for 1 cycle and `bcd`=0x00000.
- `bin`=65535 → `bcd`=0x65535 (exercises the max top digit). `bin`=1234 → `bcd`=0x01234. `bin`=40960 → `bcd`=0x40960.
- `start` reasserted with `bin`=999 at cycle 5 of a conversion of 321 → the 999 request is ignored. The result is 0x00321, with a single `done`.
- `start` held high continuously, `bin` stepping 9, 10, 99, 100 → one `done` every 17 clocks, with results 0x00009, 0x00010, 0x00099, 0x00100.
- `rst` pulsed asynchronously mid-CONV (between edges) → `bcd`=0, `busy`=0, and no `done`. A fresh `start` with 42 then gives 0x00042 after 16 clocks.
- Divider integration (`div_16`: 50000/7, its `done` driving `start`) → `bcd`=0x07142.
